// File: rtl/cond_unit.sv
// Execute-stage condition unit: holds the ARM NZCV flags, evaluates ARM condition
// codes and RISC-V beq/bne, gates E-stage write/redirect controls, counts annulled ops.
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             IsArmE,
    input  logic [3:0]       CondE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       FlagsE,
    input  logic             ZeroE,
    input  logic             BranchE,
    input  logic             BranchNeE,
    input  logic             JumpE,
    input  logic             PCSrcArmE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    output logic             CondExE,
    output logic             RegWriteGE,
    output logic             MemWriteGE,
    output logic             PCSrcE,
    output logic [3:0]       FlagsQ,
    output logic [CNT_W-1:0] AnnulCount
);

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;
    logic bubble;
    logic advance;

    assign {flag_n, flag_z, flag_c, flag_v} = FlagsQ;

    // Conditions are always judged against the registered flags, never the ALU bus,
    // so an instruction cannot observe its own flag write.
    always_comb begin
        cond_pass = 1'b1;
        case (CondE)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            default: cond_pass = 1'b1;
        endcase
    end

    assign bubble     = reset | FlushE;
    assign CondExE    = ~bubble & (IsArmE ? cond_pass : 1'b1);
    assign RegWriteGE = RegWriteE & CondExE;
    assign MemWriteGE = MemWriteE & CondExE;

    always_comb begin
        PCSrcE = 1'b0;
        if (!bubble) begin
            if (IsArmE)
                PCSrcE = PCSrcArmE & CondExE;
            else
                PCSrcE = JumpE | (BranchE & (ZeroE ^ BranchNeE));
        end
    end

    assign advance = ~FlushE & ~StallE & IsArmE;

    always_ff @(posedge clk) begin
        if (reset) begin
            FlagsQ     <= 4'b0000;
            AnnulCount <= '0;
        end else if (advance) begin
            if (CondExE) begin
                if (FlagWriteE[1]) FlagsQ[3:2] <= FlagsE[3:2];
                if (FlagWriteE[0]) FlagsQ[1:0] <= FlagsE[1:0];
            end else if (AnnulCount != {CNT_W{1'b1}}) begin
                AnnulCount <= AnnulCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit (CNT_W=2): driver pushes model expectations,
// a monitor pops and compares them just before each rising edge.
module tb_cond_unit;

    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset, StallE, FlushE, IsArmE;
    logic [3:0] CondE;
    logic [1:0] FlagWriteE;
    logic [3:0] FlagsE;
    logic ZeroE, BranchE, BranchNeE, JumpE, PCSrcArmE, RegWriteE, MemWriteE;
    logic CondExE, RegWriteGE, MemWriteGE, PCSrcE;
    logic [3:0] FlagsQ;
    logic [CNT_W-1:0] AnnulCount;

    always #5 clk = ~clk;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .IsArmE(IsArmE),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .FlagsE(FlagsE), .ZeroE(ZeroE),
        .BranchE(BranchE), .BranchNeE(BranchNeE), .JumpE(JumpE), .PCSrcArmE(PCSrcArmE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .CondExE(CondExE),
        .RegWriteGE(RegWriteGE), .MemWriteGE(MemWriteGE), .PCSrcE(PCSrcE),
        .FlagsQ(FlagsQ), .AnnulCount(AnnulCount)
    );

    typedef struct {
        logic rst, stall, flush, arm;
        logic [3:0] cond;
        logic [1:0] fw;
        logic [3:0] fl;
        logic zero, br, bne, jmp, pca, rw, mw;
    } stim_t;

    typedef struct {
        logic cx, rw, mw, pc;
        logic [3:0] flags;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    // Reference state: architectural flags as named bits, annul count as an integer.
    bit m_n, m_z, m_c, m_v;
    int m_cnt;

    function automatic logic arm_cond(input logic [3:0] cc);
        logic base;
        if (cc[3:1] == 3'b111) return 1'b1;
        case (cc[3:1])
            3'd0: base = m_z;
            3'd1: base = m_c;
            3'd2: base = m_n;
            3'd3: base = m_v;
            3'd4: base = m_c && !m_z;
            3'd5: base = (m_n == m_v);
            default: base = !m_z && (m_n == m_v);
        endcase
        return cc[0] ? !base : base;
    endfunction

    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        logic ex;
        if (s.rst || s.flush) ex = 1'b0;
        else if (s.arm)       ex = arm_cond(s.cond);
        else                  ex = 1'b1;
        e.cx = ex;
        e.rw = s.rw && ex;
        e.mw = s.mw && ex;
        if (s.rst || s.flush) e.pc = 1'b0;
        else if (s.arm)       e.pc = s.pca && ex;
        else                  e.pc = s.jmp || (s.br && (s.bne ? !s.zero : s.zero));
        e.flags = {m_n, m_z, m_c, m_v};
        e.cnt = m_cnt;
        return e;
    endfunction

    function automatic void model_update(input stim_t s);
        if (s.rst) begin
            {m_n, m_z, m_c, m_v} = 4'b0000;
            m_cnt = 0;
        end else if (!s.flush && !s.stall && s.arm) begin
            if (arm_cond(s.cond)) begin
                if (s.fw[1]) begin m_n = s.fl[3]; m_z = s.fl[2]; end
                if (s.fw[0]) begin m_c = s.fl[1]; m_v = s.fl[0]; end
            end else if (m_cnt < CNT_MAX) begin
                m_cnt = m_cnt + 1;
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset = s.rst; StallE = s.stall; FlushE = s.flush; IsArmE = s.arm;
        CondE = s.cond; FlagWriteE = s.fw; FlagsE = s.fl; ZeroE = s.zero;
        BranchE = s.br; BranchNeE = s.bne; JumpE = s.jmp; PCSrcArmE = s.pca;
        RegWriteE = s.rw; MemWriteE = s.mw;
        #1;
        e = model_out(s);
        sb.push_back(e);
        model_update(s);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst = ($urandom_range(0, 99) < 2);
        s.stall = ($urandom_range(0, 99) < 15);
        s.flush = ($urandom_range(0, 99) < 10);
        s.arm = ($urandom_range(0, 99) < 70);
        s.cond = 4'($urandom); s.fw = 2'($urandom); s.fl = 4'($urandom);
        s.zero = 1'($urandom); s.br = 1'($urandom); s.bne = 1'($urandom);
        s.jmp = ($urandom_range(0, 3) == 0); s.pca = 1'($urandom);
        s.rw = 1'($urandom); s.mw = 1'($urandom);
        return s;
    endfunction

    function automatic stim_t arm_op(input logic [3:0] cc, input logic [1:0] fw,
                                     input logic [3:0] fl);
        stim_t s = '{default: 1'b0, cond: cc, fw: fw, fl: fl};
        s.arm = 1'b1; s.rw = 1'b1; s.mw = 1'b1; s.pca = 1'b1;
        return s;
    endfunction

    function automatic stim_t rv_op(input logic zero, input logic br, input logic bne,
                                    input logic jmp);
        stim_t s = '{default: 1'b0, cond: 4'b0000, fw: 2'b11, fl: 4'b1111};
        s.zero = zero; s.br = br; s.bne = bne; s.jmp = jmp; s.rw = 1'b1;
        return s;
    endfunction

    // Monitor: the DUT presents one E-stage result per cycle; compare just before the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check("CondExE", CondExE, e.cx);
                check("RegWriteGE", RegWriteGE, e.rw);
                check("MemWriteGE", MemWriteGE, e.mw);
                check("PCSrcE", PCSrcE, e.pc);
                check("FlagsQ", FlagsQ, e.flags);
                check("AnnulCount", AnnulCount, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1; StallE = 0; FlushE = 0; IsArmE = 0; CondE = 0; FlagWriteE = 0;
        FlagsE = 0; ZeroE = 0; BranchE = 0; BranchNeE = 0; JumpE = 0; PCSrcArmE = 0;
        RegWriteE = 0; MemWriteE = 0;
        m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_cnt = 0;

        for (int i = 0; i < 2; i++) begin
            s = rand_stim(); s.rst = 1'b1;
            step(s);
        end
        step(arm_op(4'b0000, 2'b00, 4'b0000));
        step(arm_op(4'b1110, 2'b11, 4'b0100));
        @(posedge clk); #1;
        check("flags_after_write", FlagsQ, 4'b0100);
        step(arm_op(4'b0000, 2'b00, 4'b0000));
        step(arm_op(4'b0001, 2'b00, 4'b0000));

        step(arm_op(4'b1110, 2'b11, 4'b1111));
        step(arm_op(4'b1110, 2'b10, 4'b0000));
        @(posedge clk); #1;
        check("partial_nz", FlagsQ, 4'b0011);
        step(arm_op(4'b1110, 2'b01, 4'b0000));
        @(posedge clk); #1;
        check("partial_cv", FlagsQ, 4'b0000);

        step(arm_op(4'b1110, 2'b11, 4'b1001));
        for (int cc = 10; cc <= 13; cc++) step(arm_op(4'(cc), 2'b00, 4'b0000));
        step(arm_op(4'b1110, 2'b11, 4'b0010));
        step(arm_op(4'b1000, 2'b00, 4'b0000));
        step(arm_op(4'b1001, 2'b00, 4'b0000));
        step(arm_op(4'b1110, 2'b11, 4'b0110));
        step(arm_op(4'b1000, 2'b00, 4'b0000));
        step(arm_op(4'b1001, 2'b00, 4'b0000));

        step(rv_op(1'b1, 1'b1, 1'b0, 1'b0));
        step(rv_op(1'b1, 1'b1, 1'b1, 1'b0));
        step(rv_op(1'b0, 1'b0, 1'b0, 1'b1));
        step(rv_op(1'b0, 1'b1, 1'b1, 1'b0));

        s = arm_op(4'b1110, 2'b11, 4'b1010);
        s.stall = 1'b1;
        for (int i = 0; i < 3; i++) step(s);
        s.stall = 1'b0;
        step(s);
        s = arm_op(4'b1110, 2'b11, 4'b0101);
        s.flush = 1'b1;
        step(s);
        s.stall = 1'b1;
        step(s);

        step(arm_op(4'b1110, 2'b11, 4'b0000));
        for (int i = 0; i < 5; i++) step(arm_op(4'b0000, 2'b00, 4'b0000));
        @(posedge clk); #1;
        check("annul_saturated", AnnulCount, CNT_MAX);

        for (int i = 0; i < 3000; i++) step(rand_stim());

        repeat (2) @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Execute-stage consumer of the ALU's status outputs in the combined ARM/RISC-V core.
- Holds the architectural ARM NZCV flags register and updates it from the ALU Flags bus under FlagWrite control.
- Evaluates the ARM condition field and resolves RISC-V beq/bne from ZeroE.
- Gates the register-write, memory-write and PC-select controls of the instruction in E, and keeps a saturating count of annulled instructions.

Parameters:
- CNT_W, 16, width of the AnnulCount counter (saturating).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- StallE  in  1  E stage held this cycle; no state update.
- FlushE  in  1  E stage contains a bubble; gate all outputs, no state update.
- IsArmE  in  1  1 = ARM instruction in E, 0 = RISC-V.
- CondE  in  4  ARM condition field.
- FlagWriteE  in  2  bit1 = write N,Z; bit0 = write C,V (ARM only).
- FlagsE  in  4  {N,Z,C,V} from the ALU for the instruction in E.
- ZeroE  in  1  ALU result == 0 (RISC-V branch compare).
- BranchE  in  1  RISC-V conditional branch.
- BranchNeE  in  1  RISC-V branch is bne (0 = beq).
- JumpE  in  1  RISC-V jal/jalr.
- PCSrcArmE  in  1  ARM instruction redirects PC (B or write to PC).
- RegWriteE  in  1  ungated register write.
- MemWriteE  in  1  ungated memory write.
- CondExE  out  1  instruction in E executes.
- RegWriteGE  out  1  gated register write.
- MemWriteGE  out  1  gated memory write.
- PCSrcE  out  1  take branch/redirect.
- FlagsQ  out  4  current architectural {N,Z,C,V}.
- AnnulCount  out  CNT_W  number of ARM instructions annulled by a failed condition.

Behaviour:
- Reset: clk/reset are the only sync controls. reset=1 at a rising edge sets FlagsQ=4'b0000 and AnnulCount=0. While reset is high, CondExE, RegWriteGE, MemWriteGE and PCSrcE are forced to 0 combinationally. Reset mid-operation discards any pending flag write that cycle.
- Condition evaluation (combinational, from registered FlagsQ, never from FlagsE):
  - EQ 0000 = Z; NE 0001 = ~Z
  - CS 0010 = C; CC 0011 = ~C
  - MI 0100 = N; PL 0101 = ~N
  - VS 0110 = V; VC 0111 = ~V
  - HI 1000 = C&~Z; LS 1001 = ~C|Z
  - GE 1010 = N==V; LT 1011 = N!=V
  - GT 1100 = ~Z&(N==V); LE 1101 = Z|(N!=V)
  - AL 1110 = 1; 1111 = 1 (treated as always)
- CondExE:
  - IsArmE=1: the condition result above.
  - IsArmE=0: 1.
  - FlushE=1 or reset=1: forced to 0.
- Gating: RegWriteGE = RegWriteE & CondExE; MemWriteGE = MemWriteE & CondExE.
- PCSrcE:
  - ARM: PCSrcArmE & CondExE.
  - RISC-V: JumpE | (BranchE & (ZeroE ^ BranchNeE)).
  - Forced to 0 on FlushE or reset.
- Flag update at a rising edge requires all of: reset=0, StallE=0, FlushE=0, IsArmE=1, CondExE=1.
  - FlagWriteE[1]: N,Z <= FlagsE[3:2].
  - FlagWriteE[0]: C,V <= FlagsE[1:0].
  - The two halves are independent; unwritten bits hold.
- Latency:
  - New flags are visible on FlagsQ and to condition evaluation one cycle after the writing instruction's E cycle, i.e. to the next instruction entering E.
  - There is no same-cycle bypass; an instruction never sees its own flag write.
- Stall: StallE=1 freezes FlagsQ and AnnulCount. Outputs keep being evaluated from the held inputs, so they stay stable for the whole stall.
- RISC-V instructions never modify FlagsQ, whatever FlagWriteE is. Flags persist across ARM/RISC-V mode interleaving.
- AnnulCount:
  - Increments by 1 at a rising edge when reset=0, StallE=0, FlushE=0, IsArmE=1 and CondExE=0.
  - Saturates at 2^CNT_W-1; no wrap-around.
- Simultaneous events: reset > FlushE > StallE. FlushE together with StallE gives no update and gated outputs 0.
- FlagsE carry follows ARM convention: for subtraction, C=1 means no borrow. This block takes it as given.

Test Plan:
- Reset: assert reset 2 cycles with random inputs -> FlagsQ=0000, AnnulCount=0, all gated outputs 0. Release; CondE=0000 (EQ) -> CondExE=0.
- Flag write/latency: ARM, CondE=1110, FlagWriteE=11, FlagsE=0100 -> CondExE=1 that cycle, FlagsQ=0100 next cycle. Next instruction CondE=0000 with RegWriteE=1 -> RegWriteGE=1. Same with CondE=0001 -> RegWriteGE=0 and AnnulCount increments to 1.
- Partial write: FlagsQ=1111, then FlagWriteE=10 with FlagsE=0000 -> FlagsQ=0011. Then FlagWriteE=01, FlagsE=0000 -> FlagsQ=0000.
- Compound conditions: FlagsQ=1001 -> GE=1, LT=0, GT=1, LE=0. FlagsQ=0010 -> HI=1, LS=0. FlagsQ=0110 -> HI=0, LS=1.
- RISC-V branches: IsArmE=0, BranchE=1, ZeroE=1, BranchNeE=0 -> PCSrcE=1. With BranchNeE=1 -> PCSrcE=0. JumpE=1 -> PCSrcE=1. FlagWriteE=11 -> FlagsQ unchanged.
- Stall/flush/saturation (CNT_W=2): StallE=1 with a flag-writing instruction -> no change until the stall drops, then exactly one update. FlushE=1 -> no update, all gated outputs 0. Annul 5 instructions -> AnnulCount stays at 3.
